// File: rtl/fp_div_seq_if.sv
// Request/response bundle for the sequential FP divider.
// Handshake: start is taken only while ready=1; done pulses one cycle with result/err valid.
interface fp_div_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic [1:0]  dbg_state;

    modport master (
        output start, a, b,
        input  ready, done, result, err, dbg_state
    );

    modport slave (
        input  start, a, b,
        output ready, done, result, err, dbg_state
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider, restoring division at one quotient bit per clock.
// Optional round-to-nearest-even is enabled by defining FPDIV_RNE_EN; default truncates.
module fp_div_seq (
    input logic         clk,
    input logic         rst_n,
    fp_div_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [4:0]  cnt;
    logic        sign_q;
    logic        inv_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic [23:0] mb_q;
    logic [25:0] r_q;
    logic [25:0] q_q;

    logic        ge;
    logic [25:0] r_sub;

    logic signed [9:0] e_pre;
    logic signed [9:0] e_fin;
    logic [22:0] frac_pre;
    logic [22:0] frac_fin;
    logic        err_c;
    logic [31:0] res_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DIV;
            DIV:     if (cnt == 5'd25) state_nxt = NORM;
            NORM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready     = (state == IDLE);
    assign bus.dbg_state = state;

    assign ge    = (r_q >= {2'b00, mb_q});
    assign r_sub = ge ? (r_q - {2'b00, mb_q}) : r_q;

    // Quotient lies in (0.5, 2): q[25] picks between the two normalisation alignments.
    always_comb begin
        frac_pre = q_q[25] ? q_q[24:2] : q_q[23:1];
        e_pre    = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                 + (q_q[25] ? 10'sd127 : 10'sd126);
    end

`ifdef FPDIV_RNE_EN
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_rnd;

    always_comb begin
        guard    = q_q[25] ? q_q[1] : q_q[0];
        sticky   = (q_q[25] & q_q[0]) | (r_q != 26'd0);
        round_up = guard & (sticky | frac_pre[0]);
        mant_rnd = {1'b0, frac_pre} + {23'd0, round_up};
        if (mant_rnd[23]) begin
            e_fin    = e_pre + 10'sd1;
            frac_fin = 23'd0;
        end else begin
            e_fin    = e_pre;
            frac_fin = mant_rnd[22:0];
        end
    end
`else
    logic unused_rnd;
    assign unused_rnd = q_q[0];

    always_comb begin
        e_fin    = e_pre;
        frac_fin = frac_pre;
    end
`endif

    always_comb begin
        err_c = inv_q | (e_fin <= 10'sd0) | (e_fin >= 10'sd255);
        res_c = err_c ? 32'h0 : {sign_q, e_fin[7:0], frac_fin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 5'd0;
            sign_q     <= 1'b0;
            inv_q      <= 1'b0;
            ea_q       <= 8'd0;
            eb_q       <= 8'd0;
            mb_q       <= 24'd0;
            r_q        <= 26'd0;
            q_q        <= 26'd0;
            bus.done   <= 1'b0;
            bus.result <= 32'h0;
            bus.err    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_q <= bus.a[31] ^ bus.b[31];
                        inv_q  <= (bus.a[30:23] == 8'd0) | (bus.a[30:23] == 8'hFF)
                                | (bus.b[30:23] == 8'd0) | (bus.b[30:23] == 8'hFF);
                        ea_q   <= bus.a[30:23];
                        eb_q   <= bus.b[30:23];
                        mb_q   <= {1'b1, bus.b[22:0]};
                        r_q    <= {3'b001, bus.a[22:0]};
                        q_q    <= 26'd0;
                        cnt    <= 5'd0;
                    end
                end
                DIV: begin
                    q_q <= {q_q[24:0], ge};
                    r_q <= {r_sub[24:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    bus.result <= res_c;
                    bus.err    <= err_c;
                    bus.done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed vector table, handshake/reset sequences, random vs reference model.
module tb_fp_div_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_div_seq_if bus();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: quotient from integer division of the scaled significands.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        int     ea;
        int     eb;
        longint ma;
        longint mb;
        longint num;
        longint q;
        longint rem;
        int     e;
        int     frac;
        bit     g;
        bit     s;
        bit     inv;
        bit     err;
        logic [31:0] res;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        ma   = longint'({1'b1, a[22:0]});
        mb   = longint'({1'b1, b[22:0]});
        inv  = (ea == 0) || (ea == 255) || (eb == 0) || (eb == 255);
        num  = ma * (64'sd1 << 25);
        q    = num / mb;
        rem  = num % mb;
        if (q >= (64'sd1 << 25)) begin
            frac = int'((q / 4) % 8388608);
            g    = ((q / 2) % 2) != 0;
            s    = ((q % 2) != 0) || (rem != 0);
            e    = ea - eb + 127;
        end else begin
            frac = int'((q / 2) % 8388608);
            g    = (q % 2) != 0;
            s    = rem != 0;
            e    = ea - eb + 126;
        end
`ifdef FPDIV_RNE_EN
        if (g && (s || (frac % 2 == 1))) begin
            frac = frac + 1;
            if (frac == 8388608) begin
                frac = 0;
                e    = e + 1;
            end
        end
`else
        g = g & s;
`endif
        err = inv || (e <= 0) || (e >= 255);
        res = err ? 32'h0 : {a[31] ^ b[31], 8'(e), 23'(frac)};
        return {err, res};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        ex = ($urandom_range(0, 9) < 6) ? 8'($urandom_range(110, 145)) : 8'($urandom_range(0, 255));
        return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
    endfunction

    // Called at a negedge with ready=1; returns at the negedge in which done is high.
    task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic [32:0] expv,
                         input bit pulse_mid, input string name);
        int n;
        bit ready_ok;
        logic [32:0] e;
        exp_q.push_back(expv);
        check({name, " ready_before"}, 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        bus.a     = aa;
        bus.b     = bb;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n = 0;
        ready_ok = 1'b1;
        while (!bus.done && n < 40) begin
            if (bus.ready) ready_ok = 1'b0;
            if (pulse_mid && n == 5) begin
                bus.start = 1'b1;
                bus.a     = 32'h3F800000;
                bus.b     = 32'h40400000;
            end
            if (n == 6) bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        check({name, " latency"}, 64'(n), 64'd27);
        check({name, " ready_low"}, 64'(ready_ok), 64'd1);
        check({name, " result"}, 64'(bus.result), 64'(e[31:0]));
        check({name, " err"}, 64'(bus.err), 64'(e[32]));
    endtask

    int extra_done;

    initial begin
        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
`ifdef FPDIV_RNE_EN
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
`else
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
`endif
        vecs[2] = '{32'hC0F00000, 32'h3F000000, 32'hC1700000, 1'b0};
        vecs[3] = '{32'h3F800000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[4] = '{32'h7F000000, 32'h3E800000, 32'h00000000, 1'b1};
        vecs[5] = '{32'h00800000, 32'h7E000000, 32'h00000000, 1'b1};

        repeat (3) @(negedge clk);
        check("rst ready", 64'(bus.ready), 64'd1);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst result", 64'(bus.result), 64'd0);
        check("rst err", 64'(bus.err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, issued back-to-back (each start lands in the previous done cycle).
        for (int i = 0; i < 6; i++)
            issue(vecs[i].a, vecs[i].b, {vecs[i].err, vecs[i].res}, 1'b0, $sformatf("vec%0d", i));
        @(negedge clk);
        check("done one cycle", 64'(bus.done), 64'd0);
        check("result held", 64'(bus.result), 64'd0);
        check("err held", 64'(bus.err), 64'd1);

        // Explicit back-to-back 6/2 pair.
        issue(32'h40C00000, 32'h40000000, {1'b0, 32'h40400000}, 1'b0, "b2b_first");
        issue(32'h40C00000, 32'h40000000, {1'b0, 32'h40400000}, 1'b0, "b2b_second");
        @(negedge clk);

        // start pulse while busy must be ignored.
        issue(32'h40C00000, 32'h40000000, {1'b0, 32'h40400000}, 1'b1, "ignored_start");
        extra_done = 0;
        repeat (35) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check("ignored_start single_done", 64'(extra_done), 64'd0);
        check("ignored_start held", 64'(bus.result), 64'h40400000);

        // Reset in the middle of DIV.
        bus.start = 1'b1;
        bus.a     = 32'hC0F00000;
        bus.b     = 32'h3F000000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst ready", 64'(bus.ready), 64'd1);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst result", 64'(bus.result), 64'd0);
        check("midrst err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        repeat (35) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check("midrst no_done", 64'(extra_done), 64'd0);
        issue(vecs[1].a, vecs[1].b, {vecs[1].err, vecs[1].res}, 1'b0, "after_rst");
        @(negedge clk);

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = rand_fp();
            rb = rand_fp();
            issue(ra, rb, model(ra, rb), 1'b0, $sformatf("rand%0d a=%h b=%h", i, ra, rb));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
